// File: rtl/tt_chk_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int MAX_N_IN = 8;
  localparam int MAX_LAT  = 7;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_lat_pipe.sv
// DUT_LAT-deep {valid, index} delay line tracking vectors in flight; wire-through when DUT_LAT = 0.
module tt_lat_pipe #(
  parameter int N_IN    = 4,
  parameter int DUT_LAT = 0
) (
  input  logic            clk_i,
  input  logic            flush_i,
  input  logic            vld_i,
  input  logic [N_IN-1:0] idx_i,
  output logic            vld_o,
  output logic [N_IN-1:0] idx_o
);

  localparam int D = (DUT_LAT == 0) ? 1 : DUT_LAT;

  logic [D-1:0]    vld_q;
  logic [N_IN-1:0] idx_q [D];

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < D; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Index rides along untouched; only the valid tag needs flushing.
  always_ff @(posedge clk_i) begin
    idx_q[0] <= idx_i;
    for (int i = 1; i < D; i++) idx_q[i] <= idx_q[i-1];
  end

  assign vld_o = (DUT_LAT == 0) ? vld_i : vld_q[D-1];
  assign idx_o = (DUT_LAT == 0) ? idx_i : idx_q[D-1];

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps every input vector through an external netlist and compares its response
// against a loaded expected truth table.
module tt_sweep_checker
  import tt_chk_pkg::*;
#(
  parameter  int N_IN    = 4,
  parameter  int DUT_LAT = 0,
  localparam int TT_W    = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [TT_W-1:0] cfg_tt,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec,
  output logic [TT_W-1:0] obs_tt
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_e          state_q, state_d;
  logic [TT_W-1:0] exp_q, exp_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   cnt_q, cnt_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic [TT_W-1:0] obs_q, obs_d;

  logic            smp_vld;
  logic [N_IN-1:0] smp_idx;

  tt_lat_pipe #(
    .N_IN    (N_IN),
    .DUT_LAT (DUT_LAT)
  ) u_pipe (
    .clk_i   (clk),
    .flush_i (abort | ~rst_n),
    .vld_i   (state_q == RUN),
    .idx_i   (vec_q),
    .vld_o   (smp_vld),
    .idx_o   (smp_idx)
  );

  assign cfg_ready = (state_q == IDLE) || (state_q == DONE);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    vec_d   = vec_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    obs_d   = obs_q;

    if (cfg_valid && cfg_ready) exp_d = cfg_tt;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = '0;
          pass_d  = 1'b0;
          cnt_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          obs_d   = '0;
        end
      end
      RUN: begin
        if (vec_q == LAST_VEC) state_d = DRAIN;
        else                   vec_d   = vec_q + 1'b1;
      end
      default: ;
    endcase

    // The final sample overrides the RUN->DRAIN step, which makes DRAIN zero-length at DUT_LAT = 0.
    if (smp_vld) begin
      obs_d[smp_idx] = dut_out;
      if (dut_out != exp_q[smp_idx]) begin
        cnt_d = cnt_q + 1'b1;
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = smp_idx;
        end
      end
      if (smp_idx == LAST_VEC) begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = (cnt_d == '0);
      end
    end

    if (abort) begin
      state_d = IDLE;
      vec_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      cnt_d   = '0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
      obs_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      vec_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      obs_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      vec_q   <= vec_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      obs_q   <= obs_d;
    end
  end

  assign dut_in           = vec_q;
  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_cnt     = cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign obs_tt           = obs_q;

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
Parametrised equivalence checker for synthesised gate netlists (NOR/NOT designs of an N-input Boolean function).
- Holds an expected truth table loaded over a valid/ready config port.
- Drives an external DUT netlist through all 2^N_IN input vectors, one per clock, and samples the DUT output after a fixed pipeline latency.
- Reports pass/fail, mismatch count, first failing vector and the observed truth table.
- Sits between the netlist under test and the flow's result collector; it replaces per-design hand benches.

Parameters:
N_IN, 4, number of DUT inputs (1..8).
TT_W, 2**N_IN, truth-table width (derived; not overridden).
DUT_LAT, 0, cycles from dut_in change to a valid dut_out sample (0..7).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  synchronous active-low reset.
cfg_valid  input  1  expected-table load request.
cfg_ready  output  1  high when IDLE or DONE.
cfg_tt  input  TT_W  expected table; bit k = f(vector k).
start  input  1  begin sweep (level sampled).
abort  input  1  cancel sweep.
dut_in  output  N_IN  vector driven to DUT.
dut_out  input  1  DUT response.
busy  output  1  high in RUN or DRAIN.
done  output  1  one-cycle pulse on sweep completion.
pass  output  1  valid in DONE; 1 when mismatch_cnt == 0.
mismatch_cnt  output  N_IN+1  count of differing vectors.
first_fail_valid  output  1  at least one mismatch recorded.
first_fail_vec  output  N_IN  lowest-index failing vector.
obs_tt  output  TT_W  observed DUT truth table.

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE.
  - Expected-table register, dut_in, busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_vec and obs_tt all go to 0.
  - cfg_ready goes to 1.
  - Reset mid-sweep aborts immediately; no done pulse.
- States and transitions:
  - IDLE: on start, go to RUN.
  - RUN: on issuing the last vector, go to DRAIN.
  - DRAIN: on the last sample, go to DONE.
  - DONE: on start, go to RUN.
  - Any state: on abort, go to IDLE.
- Config:
  - A load happens when cfg_valid && cfg_ready at an edge.
  - If cfg and start occur in the same edge, the sweep uses the new table.
  - cfg_valid while busy is ignored (cfg_ready = 0) and not queued.
- Start:
  - At the start edge, all result outputs clear, dut_in = 0 and the state becomes RUN.
  - dut_in increments by 1 at each following edge up to TT_W-1, then holds.
  - Vector k is driven during cycle k+1 after the start edge.
  - start is ignored while busy.
- Sampling:
  - A valid-tag/index shift register of depth DUT_LAT tracks vectors in flight.
  - Vector k is sampled at the edge ending cycle k+1+DUT_LAT.
  - For DUT_LAT = 0, dut_out is sampled combinationally in the same cycle.
  - Each sample writes obs_tt[k] = dut_out.
  - If dut_out != expected[k]: mismatch_cnt increments; if this is the first mismatch, first_fail_vec = k and first_fail_valid = 1.
- Transition to DRAIN: after vector TT_W-1 is issued, the state moves to DRAIN (length DUT_LAT; zero-length when DUT_LAT = 0).
- Completion:
  - At the edge of the final sample, the state becomes DONE and pass is computed; results are valid from the next cycle.
  - done is high for exactly that one cycle; busy drops at the same time.
  - Start-to-done latency: done is high in cycle TT_W+DUT_LAT+1.
- Results persist in DONE until the next start, abort or reset.
- mismatch_cnt width N_IN+1 so the count TT_W is representable without wrap.
- Abort:
  - Return to IDLE the next cycle and clear results to reset values.
  - Keep the expected table; dut_in returns to 0; in-flight tags are flushed.
- abort and start in the same edge: abort wins.

Decomposition:
- Shared package tt_chk_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - the TT_W derivation function;
  - the constants MAX_N_IN = 8 and MAX_LAT = 7.
- One sub-module, tt_lat_pipe: parametrised DUT_LAT-deep shift register of {valid, index}, with flush input and a pass-through when DUT_LAT = 0.

Test Plan:
- N_IN=4, DUT_LAT=0, cfg_tt=0x409B, DUT behavioural model of 0x409B -> done in cycle 17 after start, pass=1, mismatch_cnt=0, obs_tt=0x409B, first_fail_valid=0.
- Same table, DUT inverted (~f) -> mismatch_cnt=16, first_fail_vec=0, obs_tt=0xBF64, pass=0.
- Same table, DUT with bit 5 flipped -> mismatch_cnt=1, first_fail_vec=5, obs_tt=0x40BB.
- DUT_LAT=2, DUT registered twice -> pass=1, done in cycle 19; DUT_LAT=2 with an unregistered DUT -> fails (detects latency mismatch).
- abort at cycle 7 -> busy=0 next cycle, results 0, no done; a restart gives a correct full result. cfg_valid during RUN -> ignored, table unchanged.
- rst_n low mid-sweep at cycle 9 -> all outputs reset values next cycle, expected table 0; start with no further cfg load -> obs_tt = DUT table and mismatches are counted against 0.
